eeg_pea_eng_opk: RTL

//  Output packer directly downstream of one PEA engine PE. Accepts clipped 8b conv results (VLD/RDY, byte address, last flag),

---
 rtl/eeg_pea_eng_opk.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/eeg_pea_eng_opk.sv
// Output packer for one PEA engine PE: packs 8b results into ORAM words with byte enables.
// Optional macro EEG_OPK_RELU_EN: negative results are written as 0 before packing.
module eeg_pea_eng_opk #(
    parameter int DATA_OUT_DW = 8,
    parameter int PACK_NUM    = 4,
    parameter int OMUX_ADD_AW = 8,
    parameter int ORAM_ADD_AW = 10,
    parameter int ORAM_DAT_DW = DATA_OUT_DW * PACK_NUM
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ORAM_ADD_AW-1:0] CFG_OUT_BASE,
    input  logic                   PE_VLD,
    input  logic                   PE_LST,
    input  logic [OMUX_ADD_AW-1:0] PE_ADD,
    input  logic [DATA_OUT_DW-1:0] PE_DAT,
    output logic                   PE_RDY,
    output logic                   ORAM_WEN,
    output logic [ORAM_ADD_AW-1:0] ORAM_ADD,
    output logic [ORAM_DAT_DW-1:0] ORAM_DAT,
    output logic [PACK_NUM-1:0]    ORAM_BEN,
    input  logic                   ORAM_RDY,
    output logic                   DONE,
    output logic                   IS_IDLE
);
    localparam int LG = $clog2(PACK_NUM);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_PACK  = 4'b0010,
        S_DRAIN = 4'b0100,
        S_DONE  = 4'b1000
    } state_e;

    state_e                 state_q, state_d;
    logic [ORAM_ADD_AW-1:0] base_q, base_d;

    logic                   pk_vld_q, pk_vld_d;
    logic                   pk_cmp_q, pk_cmp_d;
    logic                   pk_lst_q, pk_lst_d;
    logic [ORAM_ADD_AW-1:0] pk_add_q, pk_add_d;
    logic [ORAM_DAT_DW-1:0] pk_dat_q, pk_dat_d;
    logic [PACK_NUM-1:0]    pk_ben_q, pk_ben_d;

    logic                   wr_vld_q, wr_vld_d;
    logic                   wr_lst_q, wr_lst_d;
    logic [ORAM_ADD_AW-1:0] wr_add_q, wr_add_d;
    logic [ORAM_DAT_DW-1:0] wr_dat_q, wr_dat_d;
    logic [PACK_NUM-1:0]    wr_ben_q, wr_ben_d;

    logic [DATA_OUT_DW-1:0] din_byte;
    logic [LG-1:0]          lane;
    logic [PACK_NUM-1:0]    lane_oh;
    logic [ORAM_ADD_AW-1:0] base_sel;
    logic [ORAM_ADD_AW-1:0] waddr;
    logic                   same_word;
    logic                   din_ena;
    logic                   wr_ena;
    logic                   wr_free;
    logic                   evict;
    logic [ORAM_DAT_DW-1:0] ld_dat;
    logic [PACK_NUM-1:0]    ld_ben;

`ifdef EEG_OPK_RELU_EN
    assign din_byte = PE_DAT[DATA_OUT_DW-1] ? '0 : PE_DAT;
`else
    assign din_byte = PE_DAT;
`endif

    // The base register is only loaded on the first byte of a pass, so IDLE uses the live config.
    assign base_sel  = (state_q == S_IDLE) ? CFG_OUT_BASE : base_q;
    assign lane      = PE_ADD[LG-1:0];
    assign lane_oh   = PACK_NUM'(1) << lane;
    assign waddr     = ORAM_ADD_AW'(PE_ADD >> LG) + base_sel;
    assign same_word = pk_vld_q && (waddr == pk_add_q);
    assign wr_ena    = wr_vld_q & ORAM_RDY;
    assign wr_free   = ~wr_vld_q | wr_ena;
    assign din_ena   = PE_VLD & PE_RDY;

    always_comb begin
        PE_RDY = 1'b0;
        evict  = 1'b0;
        case (state_q)
            S_IDLE:  PE_RDY = 1'b1;
            S_PACK: begin
                PE_RDY = ~pk_cmp_q & (~pk_vld_q | same_word | wr_free);
                evict  = pk_vld_q & wr_free & (pk_cmp_q | (PE_VLD & ~same_word));
            end
            S_DRAIN: evict = pk_vld_q & wr_free;
            default: ;
        endcase
    end

    // Merge into the open word when addresses match, otherwise start from an empty word.
    always_comb begin
        ld_dat = same_word ? pk_dat_q : '0;
        ld_ben = (same_word ? pk_ben_q : '0) | lane_oh;
        for (int k = 0; k < PACK_NUM; k++)
            if (lane == LG'(k)) ld_dat[k*DATA_OUT_DW +: DATA_OUT_DW] = din_byte;
    end

    always_comb begin
        // NOTE: every next-state value is defaulted to its current value first so no latch is inferred.
        state_d  = state_q;
        base_d   = base_q;
        pk_vld_d = pk_vld_q;
        pk_cmp_d = pk_cmp_q;
        pk_lst_d = pk_lst_q;
        pk_add_d = pk_add_q;
        pk_dat_d = pk_dat_q;
        pk_ben_d = pk_ben_q;
        wr_vld_d = wr_vld_q;
        wr_lst_d = wr_lst_q;
        wr_add_d = wr_add_q;
        wr_dat_d = wr_dat_q;
        wr_ben_d = wr_ben_q;

        if (evict) begin
            wr_vld_d = 1'b1;
            wr_lst_d = pk_lst_q;
            wr_add_d = pk_add_q;
            wr_dat_d = pk_dat_q;
            wr_ben_d = pk_ben_q;
            pk_vld_d = 1'b0;
            pk_cmp_d = 1'b0;
            pk_lst_d = 1'b0;
            pk_add_d = '0;
            pk_dat_d = '0;
            pk_ben_d = '0;
        end else if (wr_ena) begin
            wr_vld_d = 1'b0;
        end

        if (din_ena) begin
            pk_vld_d = 1'b1;
            pk_add_d = waddr;
            pk_dat_d = ld_dat;
            pk_ben_d = ld_ben;
            pk_cmp_d = &ld_ben;
            pk_lst_d = PE_LST;
            if (state_q == S_IDLE) base_d = CFG_OUT_BASE;
            state_d = PE_LST ? S_DRAIN : S_PACK;
        end

        case (state_q)
            S_DRAIN: if (wr_ena && wr_lst_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous and clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            pk_vld_q <= 1'b0;
            pk_cmp_q <= 1'b0;
            pk_lst_q <= 1'b0;
            pk_add_q <= '0;
            pk_dat_q <= '0;
            pk_ben_q <= '0;
            wr_vld_q <= 1'b0;
            wr_lst_q <= 1'b0;
            wr_add_q <= '0;
            wr_dat_q <= '0;
            wr_ben_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            pk_vld_q <= pk_vld_d;
            pk_cmp_q <= pk_cmp_d;
            pk_lst_q <= pk_lst_d;
            pk_add_q <= pk_add_d;
            pk_dat_q <= pk_dat_d;
            pk_ben_q <= pk_ben_d;
            wr_vld_q <= wr_vld_d;
            wr_lst_q <= wr_lst_d;
            wr_add_q <= wr_add_d;
            wr_dat_q <= wr_dat_d;
            wr_ben_q <= wr_ben_d;
        end
    end

    assign ORAM_WEN = wr_vld_q;
    assign ORAM_ADD = wr_add_q;
    assign ORAM_DAT = wr_dat_q;
    assign ORAM_BEN = wr_ben_q;
    assign DONE     = (state_q == S_DONE);
    assign IS_IDLE  = (state_q == S_IDLE);

endmodule
